slow_clock_meter: RTL and testbench



---
 rtl/slow_clock_meter.sv | 164 ++++++++++++++++
 tb/tb_slow_clock_meter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/slow_clock_meter.sv
// slow_clock_meter: measures period and high time of a slow square wave
// in system-clock cycles and flags loss of the signal.
// Optional build macro SLOW_CLOCK_METER_GLITCH_FILTER_EN adds a 3-sample
// level filter between the synchronizer and the edge detector.
// Output contract: period/high_time are stable between meas_valid pulses and
// are only meaningful from the cycle meas_valid is high onwards; there is no
// ready, so a consumer must capture on the meas_valid cycle.
module slow_clock_meter #(
   parameter int CNT_WIDTH = 20,
   parameter int TIMEOUT   = 500000
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 slow_in,
   output logic [CNT_WIDTH-1:0] period,
   output logic [CNT_WIDTH-1:0] high_time,
   output logic                 meas_valid,
   output logic                 locked,
   output logic                 lost,
   output logic                 fsm_state
);

   typedef enum logic {
      WAIT_EDGE = 1'b0,
      MEASURE   = 1'b1
   } state_t;

   localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] ONE         = CNT_WIDTH'(1);

   logic sync1;
   logic sync2;
   logic level;
   logic level_d;
   logic rise;
   logic fall;

   state_t               state;
   state_t               state_nxt;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_nxt;
   logic [CNT_WIDTH-1:0] hi_cap;
   logic [CNT_WIDTH-1:0] hi_cap_nxt;
   logic [CNT_WIDTH-1:0] period_nxt;
   logic [CNT_WIDTH-1:0] high_time_nxt;
   logic                 meas_valid_nxt;
   logic                 locked_nxt;
   logic                 lost_nxt;

   // Two-flop synchronizer for the asynchronous slow input
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= slow_in;
         sync2 <= sync1;
      end
   end

`ifdef SLOW_CLOCK_METER_GLITCH_FILTER_EN
   logic [1:0] hist;
   logic       filt;
   logic       filt_nxt;

   // Filtered level follows sync2 once three consecutive samples agree;
   // using the combinational next value keeps the added latency at 2 cycles
   always_comb begin
      filt_nxt = filt;
      if ((sync2 == hist[0]) && (hist[0] == hist[1])) filt_nxt = sync2;
   end

   // Sample history and filtered level registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hist <= 2'b00;
         filt <= 1'b0;
      end else begin
         hist <= {hist[0], sync2};
         filt <= filt_nxt;
      end
   end

   assign level = filt_nxt;
`else
   assign level = sync2;
`endif

   // Delayed copy of the level for edge detection
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) level_d <= 1'b0;
      else          level_d <= level;
   end

   assign rise = level & ~level_d;
   assign fall = ~level & level_d;

   // Next-state and measurement datapath; a rise always beats the timeout
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      hi_cap_nxt     = hi_cap;
      period_nxt     = period;
      high_time_nxt  = high_time;
      meas_valid_nxt = 1'b0;
      locked_nxt     = locked;
      lost_nxt       = 1'b0;
      case (state)
         WAIT_EDGE: begin
            cnt_nxt = '0;
            if (rise) begin
               state_nxt  = MEASURE;
               cnt_nxt    = ONE;
               hi_cap_nxt = '0;
            end
         end
         MEASURE: begin
            if (rise) begin
               period_nxt     = cnt;
               high_time_nxt  = hi_cap;
               meas_valid_nxt = 1'b1;
               locked_nxt     = 1'b1;
               cnt_nxt        = ONE;
               hi_cap_nxt     = '0;
            end else if (cnt == TIMEOUT_CNT) begin
               lost_nxt   = 1'b1;
               locked_nxt = 1'b0;
               cnt_nxt    = '0;
               state_nxt  = WAIT_EDGE;
            end else begin
               cnt_nxt = cnt + ONE;
               if (fall) hi_cap_nxt = cnt;
            end
         end
         default: state_nxt = WAIT_EDGE;
      endcase
   end

   // State, counter and output registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= WAIT_EDGE;
         cnt        <= '0;
         hi_cap     <= '0;
         period     <= '0;
         high_time  <= '0;
         meas_valid <= 1'b0;
         locked     <= 1'b0;
         lost       <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         hi_cap     <= hi_cap_nxt;
         period     <= period_nxt;
         high_time  <= high_time_nxt;
         meas_valid <= meas_valid_nxt;
         locked     <= locked_nxt;
         lost       <= lost_nxt;
      end
   end

   assign fsm_state = logic'(state);

endmodule

// File: tb/tb_slow_clock_meter.sv
// tb_slow_clock_meter: directed test of slow_clock_meter with short periods
// (100-cycle square wave, TIMEOUT 300) so the run stays small.
module tb_slow_clock_meter;

   localparam int CW = 12;
   localparam int TO = 300;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          slow_in = 1'b0;
   logic [CW-1:0] period;
   logic [CW-1:0] high_time;
   logic          meas_valid;
   logic          locked;
   logic          lost;
   logic          fsm_state;

   int n_vec = 0;
   int n_fail = 0;
   int cycle = 0;
   int mv_count = 0;
   int lost_count = 0;
   int both_count = 0;
   int last_mv_cycle = 0;
   int lost_cycle = 0;
   int mv_base = 0;
   int lost_base = 0;

   slow_clock_meter #(.CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .slow_in    (slow_in),
      .period     (period),
      .high_time  (high_time),
      .meas_valid (meas_valid),
      .locked     (locked),
      .lost       (lost),
      .fsm_state  (fsm_state)
   );

   // clock / reset block
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // one clock step, sampling outputs 1 ns after the active edge
   task automatic tick();
      @(posedge clock);
      #1;
      cycle++;
      if (meas_valid) begin
         mv_count++;
         last_mv_cycle = cycle;
      end
      if (lost) begin
         lost_count++;
         lost_cycle = cycle;
      end
      if (meas_valid && lost) both_count++;
   endtask

   task automatic run_level(input logic v, input int n);
      slow_in = v;
      repeat (n) tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_period"}, 32'(period), 32'd0);
      check({tag, "_high"}, 32'(high_time), 32'd0);
      check({tag, "_mv"}, 32'(meas_valid), 32'd0);
      check({tag, "_locked"}, 32'(locked), 32'd0);
      check({tag, "_lost"}, 32'(lost), 32'd0);
      check({tag, "_state"}, 32'(fsm_state), 32'd0);
   endtask

   initial begin
      // reset state
      repeat (3) tick();
      check_all_zero("reset");
      reset_n = 1'b1;

      // 50 % duty, 100-cycle period, 4 periods
      run_level(1'b0, 10);
      run_level(1'b1, 50);
      run_level(1'b0, 50);
      check("first_rise_no_report", 32'(mv_count), 32'd0);
      check("first_rise_unlocked", 32'(locked), 32'd0);
      check("first_rise_measure", 32'(fsm_state), 32'd1);
      for (int i = 0; i < 3; i++) begin
         run_level(1'b1, 50);
         run_level(1'b0, 50);
      end
      check("sq_mv_count", 32'(mv_count), 32'd3);
      check("sq_period", 32'(period), 32'd100);
      check("sq_high", 32'(high_time), 32'd50);
      check("sq_locked", 32'(locked), 32'd1);

      // duty change: high 20 / low 80
      run_level(1'b1, 20);
      run_level(1'b0, 80);
      check("duty_prev_high", 32'(high_time), 32'd50);
      run_level(1'b1, 8);
      check("duty_mv_count", 32'(mv_count), 32'd5);
      check("duty_period", 32'(period), 32'd100);
      check("duty_high", 32'(high_time), 32'd20);

      // stop toggling -> lost exactly TO cycles after last accepted rise
      run_level(1'b0, 400);
      check("lost_count", 32'(lost_count), 32'd1);
      check("lost_delay", 32'(lost_cycle - last_mv_cycle), 32'(TO));
      check("lost_unlocked", 32'(locked), 32'd0);
      check("lost_period_hold", 32'(period), 32'd100);
      check("lost_high_hold", 32'(high_time), 32'd20);
      check("lost_state", 32'(fsm_state), 32'd0);
      check("lost_no_mv", 32'(mv_count), 32'd5);

      // restart: lock only at second rise
      run_level(1'b1, 50);
      run_level(1'b0, 50);
      check("restart_no_report", 32'(mv_count), 32'd5);
      check("restart_unlocked", 32'(locked), 32'd0);
      run_level(1'b1, 50);
      run_level(1'b0, 50);
      check("restart_mv_count", 32'(mv_count), 32'd6);
      check("restart_locked", 32'(locked), 32'd1);
      check("restart_period", 32'(period), 32'd100);

      // 1-cycle glitch high mid low phase
      mv_base = mv_count;
      run_level(1'b1, 50);
      run_level(1'b0, 20);
      run_level(1'b1, 1);
      run_level(1'b0, 29);
`ifdef SLOW_CLOCK_METER_GLITCH_FILTER_EN
      check("glitch_mv", 32'(mv_count - mv_base), 32'd1);
      check("glitch_period", 32'(period), 32'd100);
      check("glitch_high", 32'(high_time), 32'd50);
`else
      check("glitch_mv", 32'(mv_count - mv_base), 32'd2);
      check("glitch_period", 32'(period), 32'd70);
      check("glitch_high", 32'(high_time), 32'd50);
`endif
      run_level(1'b1, 50);
`ifdef SLOW_CLOCK_METER_GLITCH_FILTER_EN
      check("post_glitch_mv", 32'(mv_count - mv_base), 32'd2);
      check("post_glitch_period", 32'(period), 32'd100);
      check("post_glitch_high", 32'(high_time), 32'd50);
`else
      check("post_glitch_mv", 32'(mv_count - mv_base), 32'd3);
      check("post_glitch_period", 32'(period), 32'd30);
      check("post_glitch_high", 32'(high_time), 32'd1);
`endif
      run_level(1'b0, 50);
      run_level(1'b1, 42);
      check("recover_period", 32'(period), 32'd100);
      check("recover_high", 32'(high_time), 32'd50);

      // reset mid-period
      run_level(1'b0, 20);
      reset_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      repeat (3) tick();
      check_all_zero("mid_reset_hold");
      reset_n = 1'b1;
      mv_base = mv_count;
      run_level(1'b0, 10);
      run_level(1'b1, 50);
      run_level(1'b0, 50);
      check("post_reset_no_report", 32'(mv_count - mv_base), 32'd0);
      check("post_reset_unlocked", 32'(locked), 32'd0);
      run_level(1'b1, 8);
      check("post_reset_mv", 32'(mv_count - mv_base), 32'd1);
      check("post_reset_period", 32'(period), 32'd100);
      check("post_reset_high", 32'(high_time), 32'd50);
      check("post_reset_locked", 32'(locked), 32'd1);

      // rise on the cycle cnt == TIMEOUT: rise wins
      mv_base = mv_count;
      lost_base = lost_count;
      run_level(1'b0, TO - 8);
      run_level(1'b1, 8);
      check("edge_to_mv", 32'(mv_count - mv_base), 32'd1);
      check("edge_to_no_lost", 32'(lost_count - lost_base), 32'd0);
      check("edge_to_period", 32'(period), 32'(TO));
      check("edge_to_high", 32'(high_time), 32'd8);
      check("edge_to_locked", 32'(locked), 32'd1);

      check("mv_lost_overlap", 32'(both_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
